pcie_tlp_completer: RTL



---
 rtl/pcie_tlp_pkg.sv | 43 ++++
 rtl/pcie_cpl_mem.sv | 23 ++
 rtl/pcie_tlp_completer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pcie_tlp_pkg.sv
// Shared types and widths for the TLP completer and its assertion collateral.
package pcie_tlp_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LEN_W      = 10;
    localparam int unsigned TAG_W      = 8;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MEM_DW     = 256;
    localparam int unsigned MAX_LEN_DW = 16;
    localparam int unsigned IDX_W      = $clog2(MEM_DW);
    localparam int unsigned ERR_W      = 16;

    typedef enum logic [2:0] {
        MEMRD = 3'd0,
        MEMWR = 3'd1,
        CPL   = 3'd2,
        CPLD  = 3'd3
    } tlp_type_e;

    typedef enum logic [1:0] {
        SC = 2'd0,
        UR = 2'd1,
        CA = 2'd2
    } cpl_status_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_RD_CPL  = 2'd2,
        ST_ERR_CPL = 2'd3
    } cpl_state_e;

    // One completion beat as presented on the completion channel.
    typedef struct packed {
        tlp_type_e          kind;
        logic [LEN_W-1:0]   len_dw;
        logic [TAG_W-1:0]   tag;
        cpl_status_e        status;
        logic [DATA_W-1:0]  data;
        logic               last;
    } cpl_beat_t;

endpackage

// File: rtl/pcie_cpl_mem.sv
// Single-port DW RAM backing the completer: synchronous write, combinational read.
module pcie_cpl_mem
    import pcie_tlp_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata_c
);

    logic [DATA_W-1:0] r_mem [MEM_DW];

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/pcie_tlp_completer.sv
// Memory completer: MemRd/MemWr requests in, CplD/Cpl completions out, one request at a time.
// Optional saturating error counter port enabled by PCIE_TLP_COMPLETER_ERRCNT_EN.
module pcie_tlp_completer
    import pcie_tlp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tlp_valid,
    output logic              tlp_ready,
    input  logic [2:0]        tlp_type,
    input  logic [ADDR_W-1:0] tlp_addr,
    input  logic [LEN_W-1:0]  tlp_len_dw,
    input  logic [TAG_W-1:0]  tlp_tag,
    input  logic [DATA_W-1:0] tlp_data,
    output logic              cpl_valid,
    input  logic              cpl_ready,
    output logic [2:0]        cpl_type,
    output logic [LEN_W-1:0]  cpl_len_dw,
    output logic [TAG_W-1:0]  cpl_tag,
    output logic [1:0]        cpl_status,
    output logic [DATA_W-1:0] cpl_data,
    output logic              cpl_last
`ifdef PCIE_TLP_COMPLETER_ERRCNT_EN
    ,
    output logic [ERR_W-1:0]  err_cnt
`endif
);

    cpl_state_e         r_state, w_state_nxt;
    logic               r_tlp_ready, w_tlp_ready_nxt;
    logic               r_cpl_valid, w_cpl_valid_nxt;
    cpl_beat_t          r_cpl, w_cpl_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [LEN_W-1:0]   r_rem, w_rem_nxt;
    logic               r_drop, w_drop_nxt;

    logic               w_accept;
    logic [IDX_W-1:0]   w_hdr_idx;
    logic [ADDR_W:0]    w_hdr_end;
    logic               w_malformed;
    logic               w_bad_addr;
    logic               w_mem_we;
    logic [IDX_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]  w_mem_rdata;

    assign w_accept    = tlp_valid && r_tlp_ready;
    assign w_hdr_idx   = tlp_addr[IDX_W+1:2];
    assign w_hdr_end   = (ADDR_W+1)'(tlp_addr >> 2) + (ADDR_W+1)'(tlp_len_dw);
    assign w_malformed = (tlp_len_dw == '0) || (tlp_len_dw > LEN_W'(MAX_LEN_DW));
    assign w_bad_addr  = (tlp_addr[1:0] != 2'b00) || (w_hdr_end > (ADDR_W+1)'(MEM_DW));

    pcie_cpl_mem u_mem (
        .clk       (clk),
        .i_we      (w_mem_we),
        .i_addr    (w_mem_addr),
        .i_wdata   (tlp_data),
        .o_rdata_c (w_mem_rdata)
    );

    // Next-state and next-output logic; r_ptr always points at the next DW to touch.
    always_comb begin
        w_state_nxt     = r_state;
        w_cpl_valid_nxt = r_cpl_valid;
        w_cpl_nxt       = r_cpl;
        w_ptr_nxt       = r_ptr;
        w_rem_nxt       = r_rem;
        w_drop_nxt      = r_drop;
        w_mem_we        = 1'b0;
        w_mem_addr      = r_ptr;

        case (r_state)
            ST_IDLE: begin
                w_mem_addr = w_hdr_idx;
                if (w_accept) begin
                    w_ptr_nxt = w_hdr_idx + IDX_W'(1);
                    w_rem_nxt = tlp_len_dw - LEN_W'(1);
                    if (tlp_type == MEMWR) begin
                        if (!w_malformed) begin
                            w_mem_we   = !w_bad_addr;
                            w_drop_nxt = w_bad_addr;
                            if (tlp_len_dw > LEN_W'(1)) begin
                                w_state_nxt = ST_WR_DATA;
                            end
                        end
                    end else if ((tlp_type == MEMRD) && !w_malformed && !w_bad_addr) begin
                        w_state_nxt      = ST_RD_CPL;
                        w_cpl_valid_nxt  = 1'b1;
                        w_cpl_nxt.kind   = CPLD;
                        w_cpl_nxt.len_dw = tlp_len_dw;
                        w_cpl_nxt.tag    = tlp_tag;
                        w_cpl_nxt.status = SC;
                        w_cpl_nxt.data   = w_mem_rdata;
                        w_cpl_nxt.last   = (tlp_len_dw == LEN_W'(1));
                    end else begin
                        w_state_nxt      = ST_ERR_CPL;
                        w_cpl_valid_nxt  = 1'b1;
                        w_cpl_nxt.kind   = CPL;
                        w_cpl_nxt.len_dw = '0;
                        w_cpl_nxt.tag    = tlp_tag;
                        w_cpl_nxt.data   = '0;
                        w_cpl_nxt.last   = 1'b1;
                        if (tlp_type == MEMRD) begin
                            w_cpl_nxt.status = UR;
                        end else begin
                            w_cpl_nxt.status = CA;
                        end
                    end
                end
            end

            ST_WR_DATA: begin
                if (w_accept) begin
                    w_mem_we  = !r_drop;
                    w_ptr_nxt = r_ptr + IDX_W'(1);
                    w_rem_nxt = r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_RD_CPL: begin
                if (cpl_ready) begin
                    if (r_cpl.last) begin
                        w_state_nxt     = ST_IDLE;
                        w_cpl_valid_nxt = 1'b0;
                        w_cpl_nxt.last  = 1'b0;
                    end else begin
                        w_cpl_nxt.data = w_mem_rdata;
                        w_cpl_nxt.last = (r_rem == LEN_W'(1));
                        w_ptr_nxt      = r_ptr + IDX_W'(1);
                        w_rem_nxt      = r_rem - LEN_W'(1);
                    end
                end
            end

            ST_ERR_CPL: begin
                if (cpl_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_cpl_valid_nxt = 1'b0;
                    w_cpl_nxt.last  = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_tlp_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_WR_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tlp_ready <= 1'b0;
            r_cpl_valid <= 1'b0;
            r_cpl       <= '0;
            r_ptr       <= '0;
            r_rem       <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tlp_ready <= w_tlp_ready_nxt;
            r_cpl_valid <= w_cpl_valid_nxt;
            r_cpl       <= w_cpl_nxt;
            r_ptr       <= w_ptr_nxt;
            r_rem       <= w_rem_nxt;
            r_drop      <= w_drop_nxt;
        end
    end

    assign tlp_ready  = r_tlp_ready;
    assign cpl_valid  = r_cpl_valid;
    assign cpl_type   = r_cpl.kind;
    assign cpl_len_dw = r_cpl.len_dw;
    assign cpl_tag    = r_cpl.tag;
    assign cpl_status = r_cpl.status;
    assign cpl_data   = r_cpl.data;
    assign cpl_last   = r_cpl.last;

`ifdef PCIE_TLP_COMPLETER_ERRCNT_EN
    logic              w_err_evt;
    logic [ERR_W-1:0]  r_err_cnt;

    // One event per header that is not a well-formed, in-range MemRd/MemWr.
    assign w_err_evt = (r_state == ST_IDLE) && w_accept &&
                       !(((tlp_type == MEMRD) || (tlp_type == MEMWR)) && !w_malformed && !w_bad_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_err_evt && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
